// File: rtl/div_mon_pkg.sv
// rtl/div_mon_pkg.sv - shared state type and default constants for the divided-clock monitor.
package div_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_MEAS   = 2'd2,
      ST_LOCKED = 2'd3
   } mon_state_t;

   localparam int DEF_CNT_W      = 8;
   localparam int DEF_LOCK_CNT   = 4;
   localparam int DEF_TIMEOUT_HC = 200;

endpackage

// File: rtl/div_mon_sampler.sv
// rtl/div_mon_sampler.sv - dual-edge capture of div_clk, realigned to posedge as an ordered sample triple.
module div_mon_sampler
   import div_mon_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       div_clk,
   output logic [1:0] level,
   output logic [1:0] rise,
   output logic [1:0] fall
);

   logic s_n;
   logic s_n_q;
   logic s_p;
   logic prev_p;

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         s_n <= 1'b0;
      end else begin
         s_n <= div_clk;
      end
   end

   // s_n is overwritten mid-cycle, so it is held at posedge to stay between prev_p and s_p in time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_n_q  <= 1'b0;
         s_p    <= 1'b0;
         prev_p <= 1'b0;
      end else begin
         s_n_q  <= s_n;
         s_p    <= div_clk;
         prev_p <= s_p;
      end
   end

   assign level = {s_p, s_n_q};
   assign rise  = {~s_n_q & s_p, ~prev_p & s_n_q};
   assign fall  = {s_n_q & ~s_p, prev_p & ~s_n_q};

endmodule

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - measures high/low/period of a divided clock in clk half-cycles, with lock and timeout.
module div_clk_monitor
   import div_mon_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int LOCK_CNT   = DEF_LOCK_CNT,
   parameter int TIMEOUT_HC = DEF_TIMEOUT_HC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             div_clk,
   output logic [CNT_W-1:0] high_hc,
   output logic [CNT_W-1:0] low_hc,
   output logic [CNT_W-1:0] period_hc,
   output logic             meas_valid,
   output logic             duty_ok,
   output logic             locked,
   output logic             timeout
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_HC);
   localparam logic [MW-1:0]    LOCK_LIM = MW'(LOCK_CNT);
   localparam logic [MW-1:0]    M_ONE    = MW'(1);

   logic [1:0] level;
   logic [1:0] rise;
   logic [1:0] fall;

   div_mon_sampler u_sampler (
      .clk     (clk),
      .rst     (rst),
      .div_clk (div_clk),
      .level   (level),
      .rise    (rise),
      .fall    (fall)
   );

   mon_state_t       state;
   logic [CNT_W-1:0] hi_cnt;
   logic [CNT_W-1:0] lo_cnt;
   logic [CNT_W-1:0] idle_cnt;
   logic [MW-1:0]    match_cnt;

   logic [CNT_W-1:0] hi_nx;
   logic [CNT_W-1:0] lo_nx;
   logic [CNT_W-1:0] idle_nx;
   logic [CNT_W-1:0] cap_hi;
   logic [CNT_W-1:0] cap_lo;
   logic [CNT_W-1:0] per_nx;
   logic [MW-1:0]    match_nx;
   logic             synced;
   logic             done;
   logic             sync_hit;
   logic             timeout_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction

   // Walk both half-cycles in order so a 1-half-cycle pulse yields its rise and its fall.
   always_comb begin
      hi_nx    = hi_cnt;
      lo_nx    = lo_cnt;
      idle_nx  = idle_cnt;
      cap_hi   = high_hc;
      cap_lo   = low_hc;
      done     = 1'b0;
      sync_hit = 1'b0;
      synced   = (state == ST_MEAS) || (state == ST_LOCKED);
      for (int i = 0; i < 2; i++) begin
         if (rise[i]) begin
            if (synced) begin
               done   = 1'b1;
               cap_hi = hi_nx;
               cap_lo = lo_nx;
            end else begin
               sync_hit = 1'b1;
            end
            synced = 1'b1;
            hi_nx  = ONE;
            lo_nx  = '0;
         end else if (fall[i]) begin
            lo_nx = ONE;
         end else if (level[i]) begin
            hi_nx = sat_inc(hi_nx);
         end else begin
            lo_nx = sat_inc(lo_nx);
         end
         idle_nx = (rise[i] | fall[i]) ? '0 : sat_inc(idle_nx);
      end
      per_nx      = cap_hi + cap_lo;
      timeout_hit = (state != ST_IDLE) && (idle_nx >= TO_LIM);
      // A zero match count means no earlier period exists since sync, so nothing to compare against.
      match_nx    = ((match_cnt == '0) || (per_nx != period_hc)) ? M_ONE : match_cnt + M_ONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         hi_cnt     <= '0;
         lo_cnt     <= '0;
         idle_cnt   <= '0;
         match_cnt  <= '0;
         high_hc    <= '0;
         low_hc     <= '0;
         period_hc  <= '0;
         meas_valid <= 1'b0;
         duty_ok    <= 1'b0;
         locked     <= 1'b0;
         timeout    <= 1'b0;
      end else if (!enable) begin
         state      <= ST_IDLE;
         idle_cnt   <= '0;
         match_cnt  <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         hi_cnt     <= hi_nx;
         lo_cnt     <= lo_nx;
         idle_cnt   <= idle_nx;
         case (state)
            ST_IDLE: begin
               state     <= ST_SYNC;
               idle_cnt  <= '0;
               match_cnt <= '0;
            end
            default: begin
               if (timeout_hit) begin
                  timeout   <= 1'b1;
                  locked    <= 1'b0;
                  state     <= ST_SYNC;
                  idle_cnt  <= '0;
                  match_cnt <= '0;
               end else begin
                  if ((state == ST_SYNC) && sync_hit) begin
                     state <= ST_MEAS;
                  end
                  if (done) begin
                     high_hc    <= cap_hi;
                     low_hc     <= cap_lo;
                     period_hc  <= per_nx;
                     duty_ok    <= (cap_hi == cap_lo);
                     meas_valid <= 1'b1;
                     if (state == ST_LOCKED) begin
                        if (per_nx != period_hc) begin
                           locked    <= 1'b0;
                           match_cnt <= M_ONE;
                           state     <= ST_MEAS;
                        end
                     end else begin
                        match_cnt <= match_nx;
                        if (match_nx == LOCK_LIM) begin
                           locked <= 1'b1;
                           state  <= ST_LOCKED;
                        end
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb/tb_div_clk_monitor.sv - randomized run-length stimulus with a scoreboard of expected measurements.
module tb_div_clk_monitor;

   localparam int CNT_W      = 8;
   localparam int LOCK_CNT   = 4;
   localparam int TIMEOUT_HC = 200;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             enable = 1'b0;
   logic             div_clk = 1'b0;
   logic [CNT_W-1:0] high_hc;
   logic [CNT_W-1:0] low_hc;
   logic [CNT_W-1:0] period_hc;
   logic             meas_valid;
   logic             duty_ok;
   logic             locked;
   logic             timeout;

   typedef struct {
      int hi;
      int lo;
      int per;
      int duty;
      int lk;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   runs[$];
   int   n_checks = 0;
   int   n_pass = 0;

   div_clk_monitor #(
      .CNT_W      (CNT_W),
      .LOCK_CNT   (LOCK_CNT),
      .TIMEOUT_HC (TIMEOUT_HC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .div_clk    (div_clk),
      .high_hc    (high_hc),
      .low_hc     (low_hc),
      .period_hc  (period_hc),
      .meas_valid (meas_valid),
      .duty_ok    (duty_ok),
      .locked     (locked),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Reference: runs alternate high/low starting high; each high run after the first closes a period.
   task automatic push_model();
      int prev_per = -1;
      int eq_run = 0;
      for (int i = 2; i < runs.size(); i += 2) begin
         exp_t e;
         e.hi     = runs[i-2];
         e.lo     = runs[i-1];
         e.per    = (e.hi + e.lo) % 256;
         e.duty   = (e.hi == e.lo) ? 1 : 0;
         eq_run   = (e.per == prev_per) ? eq_run + 1 : 1;
         prev_per = e.per;
         e.lk     = (eq_run >= LOCK_CNT) ? 1 : 0;
         exp_q.push_back(e);
      end
   endtask

   task automatic add_periods(input int h, input int l, input int n);
      repeat (n) begin
         runs.push_back(h);
         runs.push_back(l);
      end
   endtask

   task automatic play();
      foreach (runs[i]) begin
         for (int j = 0; j < runs[i]; j++) begin
            @(clk);
            #1 div_clk = (i % 2 == 0);
         end
      end
      @(clk);
      #1 div_clk = 1'b0;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 60) begin
         @(posedge clk);
         t++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic restart();
      @(posedge clk);
      #2 enable = 1'b0;
      repeat (3) @(posedge clk);
      #2 enable = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic go(input string name, input bit do_restart);
      runs.push_back(runs[runs.size()-2]);
      if (do_restart) restart();
      push_model();
      play();
      drain(name);
      runs.delete();
   endtask

   always @(negedge clk) begin
      if (meas_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_meas: got meas_valid with high_hc=%0d low_hc=%0d, required none", high_hc, low_hc);
         end else begin
            mon_e = exp_q.pop_front();
            check("high_hc", int'(high_hc), mon_e.hi);
            check("low_hc", int'(low_hc), mon_e.lo);
            check("period_hc", int'(period_hc), mon_e.per);
            check("duty_ok", int'(duty_ok), mon_e.duty);
            check("locked", int'(locked), mon_e.lk);
         end
      end
   end

   initial begin
      #12;
      check("rst_high_hc", int'(high_hc), 0);
      check("rst_period_hc", int'(period_hc), 0);
      check("rst_meas_valid", int'(meas_valid), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_timeout", int'(timeout), 0);
      @(negedge clk);
      rst = 1'b1;

      add_periods(3, 3, $urandom_range(5, 8));
      go("drain_div3", 1'b1);
      add_periods(5, 5, $urandom_range(5, 8));
      go("drain_div5", 1'b1);
      add_periods(5, 3, $urandom_range(5, 8));
      go("drain_5_3", 1'b1);
      add_periods(3, 3, 6);
      add_periods(3, 5, 1);
      add_periods(5, 5, 6);
      go("drain_switch", 1'b1);
      add_periods(1, 1, $urandom_range(6, 10));
      go("drain_min_pulse", 1'b1);

      for (int s = 0; s < 4; s++) begin
         int np;
         np = $urandom_range(3, 6);
         for (int p = 0; p < np; p++)
            add_periods($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 6));
         go("drain_random", 1'b1);
      end

      add_periods(3, 3, 6);
      go("drain_pre_timeout", 1'b1);
      check("locked_before_timeout", int'(locked), 1);
      repeat (85) @(posedge clk);
      #1 check("timeout_early", int'(timeout), 0);
      repeat (30) @(posedge clk);
      #1 check("timeout_set", int'(timeout), 1);
      check("timeout_locked", int'(locked), 0);
      add_periods(5, 5, 5);
      go("drain_after_timeout", 1'b0);
      check("timeout_sticky", int'(timeout), 1);
      @(posedge clk);
      #2 enable = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("timeout_cleared", int'(timeout), 0);
      check("disable_locked", int'(locked), 0);

      add_periods(3, 3, 5);
      go("drain_pre_reset", 1'b1);
      check("locked_before_reset", int'(locked), 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("mid_rst_high_hc", int'(high_hc), 0);
      check("mid_rst_low_hc", int'(low_hc), 0);
      check("mid_rst_period_hc", int'(period_hc), 0);
      check("mid_rst_duty_ok", int'(duty_ok), 0);
      check("mid_rst_locked", int'(locked), 0);
      check("mid_rst_meas_valid", int'(meas_valid), 0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      add_periods(3, 3, 3);
      go("drain_post_reset", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

endmodule
